// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite write master.
// Holds the FSM state encoding and the BRESP response codes.
package axil_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_ADDR_DATA = 2'b01,
    S_RESP      = 2'b10,
    S_DONE      = 2'b11
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_write_master.sv
// Single-beat AXI4-Lite write master: takes one user command, issues AW and W
// independently, waits for B, then reports the response to the user.
module axil_write_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [1:0]              done_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  axil_state_t state_r;
  axil_state_t state_next_s;
  logic        aw_done_r;
  logic        w_done_r;
  logic        cmd_hs_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        b_hs_s;
  logic        both_done_s;

  assign cmd_ready  = (state_r == S_IDLE);
  assign bready     = (state_r == S_RESP);
  assign done_valid = (state_r == S_DONE);
  assign awprot     = 3'b000;

  assign cmd_hs_s    = cmd_valid & cmd_ready;
  assign aw_hs_s     = awvalid & awready;
  assign w_hs_s      = wvalid & wready;
  assign b_hs_s      = bvalid & bready;
  // A handshake completing this cycle counts as done, so AW and W may finish together.
  assign both_done_s = (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next_s = S_ADDR_DATA;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ADDR_DATA: begin
        if (both_done_s) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_ADDR_DATA;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_RESP;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Command payload capture; held until the next command is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      awaddr <= {ADDR_WIDTH{1'b0}};
      wdata  <= {DATA_WIDTH{1'b0}};
      wstrb  <= {(DATA_WIDTH/8){1'b0}};
    end else if (cmd_hs_s) begin
      awaddr <= cmd_addr;
      wdata  <= cmd_data;
      wstrb  <= cmd_strb;
    end
  end

  // AW/W valids and their completion flags, each channel tracked on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (cmd_hs_s) begin
      awvalid   <= 1'b1;
      wvalid    <= 1'b1;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        awvalid   <= 1'b0;
        aw_done_r <= 1'b1;
      end
      if (w_hs_s) begin
        wvalid   <= 1'b0;
        w_done_r <= 1'b1;
      end
    end
  end

  // Write response capture; stable through S_DONE since B is only accepted in S_RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_resp <= RESP_OKAY;
    end else if (b_hs_s) begin
      done_resp <= bresp;
    end
  end

endmodule

// File: tb/tb_axil_write_master.sv
// Directed bench for axil_write_master: cycle-exact checks of the AW/W/B
// sequencing with a response scoreboard, plus idle-B and mid-flight reset cases.
module tb_axil_write_master;
  import axil_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        done_valid;
  logic        done_ready;
  logic [1:0]  done_resp;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks;
  int failures;
  logic [1:0] sb_q[$];

  axil_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_strb   (cmd_strb),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_resp  (done_resp),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    cmd_addr   = 32'h0;
    cmd_data   = 32'h0;
    cmd_strb   = 4'h0;
    done_ready = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    bresp      = 2'b00;
  endtask

  // One full write; awd/wd/bd are slave delays after valids appear, dd is user delay.
  // Sample k is the k-th falling edge after the accepting rising edge (cycle T+k).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awd, input int wd, input int bd, input int dd, input logic [1:0] resp);
    int kb;
    int kd;
    int kend;
    bit seen;
    logic [1:0] held;
    logic [1:0] exp_resp;
    kb   = 1 + ((awd > wd) ? awd : wd);
    kd   = kb + 2 + bd;
    kend = kd + dd + 1;
    seen = 1'b0;
    held = 2'b00;
    @(negedge clk);
    check("pre_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_strb  = strb;
    sb_q.push_back(resp);
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      if (k < kend) begin
        check("awaddr", 64'(awaddr), 64'(addr));
        check("wdata", 64'(wdata), 64'(data));
        check("wstrb", 64'(wstrb), 64'(strb));
        check("awprot", 64'(awprot), 64'(3'b000));
        check("awvalid", 64'(awvalid), 64'(k <= 1 + awd));
        check("wvalid", 64'(wvalid), 64'(k <= 1 + wd));
        check("bready", 64'(bready), 64'((k > kb) && (k <= kb + 1 + bd)));
        check("done_valid", 64'(done_valid), 64'(k >= kd));
        check("busy_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        if (done_valid && !seen) begin
          seen = 1'b1;
          held = done_resp;
          if (sb_q.size() == 0) begin
            check("sb_unexpected_done", 64'(1'b1), 64'(1'b0));
          end else begin
            exp_resp = sb_q.pop_front();
            check("done_resp", 64'(done_resp), 64'(exp_resp));
          end
        end else if (done_valid) begin
          check("done_resp_stable", 64'(done_resp), 64'(held));
        end
      end else begin
        check("end_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        check("end_done_valid", 64'(done_valid), 64'(1'b0));
        check("end_awvalid", 64'(awvalid), 64'(1'b0));
        check("end_wvalid", 64'(wvalid), 64'(1'b0));
        check("end_bready", 64'(bready), 64'(1'b0));
      end
      cmd_valid  = 1'b0;
      cmd_addr   = 32'h0;
      cmd_data   = 32'h0;
      cmd_strb   = 4'h0;
      awready    = (k == 1 + awd);
      wready     = (k == 1 + wd);
      bvalid     = (k == kb + 1 + bd);
      bresp      = bvalid ? resp : 2'b00;
      done_ready = (k == kd + dd);
    end
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle_inputs();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_awvalid", 64'(awvalid), 64'(1'b0));
    check("rst_wvalid", 64'(wvalid), 64'(1'b0));
    check("rst_bready", 64'(bready), 64'(1'b0));
    check("rst_done_valid", 64'(done_valid), 64'(1'b0));
    check("rst_done_resp", 64'(done_resp), 64'(2'b00));
    check("rst_awaddr", 64'(awaddr), 64'(32'h0));
    check("rst_wdata", 64'(wdata), 64'(32'h0));
    check("rst_wstrb", 64'(wstrb), 64'(4'h0));
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));

    // Zero-wait slave.
    run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, RESP_OKAY);
    // AW late, W immediate.
    run_txn(32'h0000_1234, 32'h0102_0304, 4'h3, 4, 0, 0, 0, RESP_EXOKAY);
    // W late, AW immediate, slave error.
    run_txn(32'hA000_0000, 32'hCAFE_F00D, 4'hC, 0, 3, 0, 0, RESP_SLVERR);
    // Slow B and user holding off completion.
    run_txn(32'hFFFF_FFFC, 32'h5555_AAAA, 4'h1, 1, 1, 2, 5, RESP_DECERR);
    // Both channels late, finishing together.
    run_txn(32'h0000_0040, 32'h1357_9BDF, 4'h5, 2, 2, 0, 1, RESP_OKAY);

    // B activity while idle is ignored.
    @(negedge clk);
    bvalid = 1'b1;
    bresp  = RESP_SLVERR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_b_bready", 64'(bready), 64'(1'b0));
      check("idle_b_cmd_ready", 64'(cmd_ready), 64'(1'b1));
      check("idle_b_done_valid", 64'(done_valid), 64'(1'b0));
    end
    idle_inputs();

    // Reset while AW/W outstanding.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0080;
    cmd_data  = 32'h7777_8888;
    cmd_strb  = 4'hF;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("pre_rst_awvalid", 64'(awvalid), 64'(1'b1));
    check("pre_rst_wvalid", 64'(wvalid), 64'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    check("async_awvalid", 64'(awvalid), 64'(1'b0));
    check("async_wvalid", 64'(wvalid), 64'(1'b0));
    check("async_bready", 64'(bready), 64'(1'b0));
    check("async_done_valid", 64'(done_valid), 64'(1'b0));
    check("async_awaddr", 64'(awaddr), 64'(32'h0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
      check("after_rst_done_valid", 64'(done_valid), 64'(1'b0));
      check("after_rst_awvalid", 64'(awvalid), 64'(1'b0));
    end
    check("after_rst_sb", 64'(sb_q.size()), 64'(0));

    // Normal operation resumes.
    run_txn(32'h0000_0100, 32'h0BAD_C0DE, 4'hA, 1, 0, 1, 2, RESP_EXOKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_write_master.md
AXIL_WRITE_MASTER -- requirements
Module: axil_write_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning AXI4-Lite data width, 32 or 64 only.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have ports: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have user command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in ADDR_WIDTH; cmd_data in DATA_WIDTH; cmd_strb in DATA_WIDTH/8.
REQ-006 SHALL have user completion ports: done_valid out 1; done_ready in 1; done_resp out 2 (AXI BRESP code).
REQ-007 SHALL have AXI AW ports: awaddr out ADDR_WIDTH; awprot out 3 (constant 3'b000); awvalid out 1; awready in 1.
REQ-008 SHALL have AXI W ports: wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wvalid out 1; wready in 1.
REQ-009 SHALL have AXI B ports: bresp in 2; bvalid in 1; bready out 1.

Function
REQ-010 SHALL implement states S_IDLE, S_ADDR_DATA, S_RESP and S_DONE; unreachable encodings SHALL go to S_IDLE.
REQ-011 SHALL drive cmd_ready = (state == S_IDLE), combinationally from state only.
REQ-012 SHALL, on cmd_valid & cmd_ready, register cmd_addr/cmd_data/cmd_strb into awaddr/wdata/wstrb, set awvalid=1 and wvalid=1 the next cycle, and enter S_ADDR_DATA.
REQ-013 SHALL hold awaddr, wdata and wstrb stable from command acceptance until return to S_IDLE.
REQ-014 SHALL keep awvalid and wvalid registered and never combinationally dependent on awready, wready or bvalid.
REQ-015 SHALL deassert awvalid the cycle after awvalid & awready, and deassert wvalid the cycle after wvalid & wready, tracking each with independent done flags.
REQ-016 SHALL accept AW and W handshakes in either order or in the same cycle; S_ADDR_DATA SHALL exit to S_RESP only once both have completed, including when both complete in the same cycle.
REQ-017 SHALL drive bready = (state == S_RESP); bvalid in any other state SHALL be ignored.
REQ-018 SHALL, on bvalid & bready, capture bresp into done_resp and enter S_DONE.
REQ-019 SHALL drive done_valid = (state == S_DONE) with done_resp stable while done_valid is high.
REQ-020 SHALL, on done_valid & done_ready, return to S_IDLE; cmd_ready SHALL be high the following cycle.
REQ-021 SHALL achieve minimum latency, command accept (cycle T) to done_valid, of 3 cycles: AW/W valid at T+1, bready at T+2, done_valid at T+3 with zero-wait slave.
REQ-022 SHALL hold awvalid/wvalid high indefinitely while awready/wready stay low; there is no timeout.
REQ-023 SHALL pass every BRESP value (OKAY, EXOKAY, SLVERR, DECERR) unmodified to done_resp.

Reset
REQ-024 SHALL, while reset_n is low, immediately force state=S_IDLE, awvalid=0, wvalid=0, bready=0, done_valid=0, done_resp=2'b00, both done flags=0, awaddr/wdata/wstrb=0.
REQ-025 SHALL abandon any in-flight transaction on reset assertion, with no completion reported; cmd_ready SHALL be 1 on the first clock after reset_n deasserts.

Structure
REQ-026 SHALL take state encodings and BRESP code constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) from a shared package axil_pkg.
REQ-027 SHALL be a single module with no sub-modules; AW and W tracking is two flag registers inside it.

Verification
REQ-028 Zero-wait slave, cmd addr=0x10 data=0xDEADBEEF strb=0xF -> awaddr=0x10, wdata=0xDEADBEEF at T+1; done_valid at T+3; done_resp=00.
REQ-029 awready delayed 4 cycles, wready immediate -> wvalid drops at T+2, awvalid holds to T+5; bready not asserted before both handshakes complete.
REQ-030 wready delayed 3 cycles, awready immediate, bresp=2'b10 -> done_resp=2'b10; awaddr/wdata stable throughout.
REQ-031 done_ready held low 5 cycles -> done_valid and done_resp stay stable; cmd_ready remains 0 until 1 cycle after done_ready.
REQ-032 reset_n pulsed low while in S_ADDR_DATA -> awvalid, wvalid, bready and done_valid go 0 without a clock edge; cmd_ready=1 after release; no done_valid reported.
REQ-033 bvalid asserted spuriously while in S_IDLE -> ignored, bready stays 0, state unchanged.
